led_pulse_stretcher: RTL and testbench

//  Converts single-cycle event pulses (e.g. the debounced button pulse) into human-visible LED blinks.

---
 rtl/led_stretch_pkg.sv | 19 +
 rtl/led_pulse_stretcher_pend_counter.sv | 38 +++
 rtl/led_pulse_stretcher.sv | 146 ++++++++++++++
 tb/tb_led_pulse_stretcher.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
//   state_t   : blink FSM states
//   cnt_width : width of the per-phase cycle counter, $clog2(max(hold,gap)+1)
package led_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_pend_counter.sv
// pend_counter: saturating up/down counter of queued blink requests.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc      : one new event to queue
//   dec      : one queued event consumed
//   count    : registered queue depth
//   full     : count at 2**W-1
//   drop     : inc that cannot be stored this cycle (full, no matching dec)
module pend_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         drop
);

  logic [W-1:0] r_count;

  assign count = r_count;
  assign full  = (r_count == '1);
  // Simultaneous inc and dec cancel, so a full counter only drops when no dec.
  assign drop  = inc & ~dec & full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !dec && !full) begin
      r_count <= r_count + W'(1);
    end else if (dec && !inc && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns single-cycle event pulses into visible LED
// blinks of HOLD_CYCLES on followed by GAP_CYCLES off; events arriving
// mid-blink are queued and replayed back to back.
// Optional feature macro: LED_STRETCH_OVF_EN adds the sticky ovf output.
// Ports:
//   clk     : system clock, posedge
//   rst     : synchronous active-high reset
//   pls_in  : event pulse, each high sampled cycle is one event
//   led_out : registered LED drive
//   busy    : registered, high while in ST_ON or ST_GAP
//   pending : registered count of queued, not-yet-started blinks
//   ovf     : sticky flag, an event was dropped at saturation (macro only)
module led_pulse_stretcher
  import led_stretch_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pls_in,
  output logic              led_out,
  output logic              busy,
`ifdef LED_STRETCH_OVF_EN
  output logic [PEND_W-1:0] pending,
  output logic              ovf
`else
  output logic [PEND_W-1:0] pending
`endif
);

  localparam int unsigned   CW        = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_next;
  logic                r_led;
  logic                r_busy;
  logic                w_inc;
  logic                w_dec;
  logic                w_full;
  logic                w_drop;
  logic [PEND_W-1:0]   w_count;
  logic                w_unused_full;

  assign w_unused_full = w_full;

  pend_counter #(
    .W(PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc),
    .dec   (w_dec),
    .count (w_count),
    .full  (w_full),
    .drop  (w_drop)
  );

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pls_in) begin
          w_next     = ST_ON;
          w_cnt_next = '0;
        end
      end
      ST_ON: begin
        w_inc = pls_in;
        if (r_cnt == HOLD_LAST) begin
          w_next     = ST_GAP;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_next = '0;
          // Queued events take priority; a live pulse is then queued instead,
          // giving a net-zero pending change.
          if (w_count != '0) begin
            w_next = ST_ON;
            w_dec  = 1'b1;
            w_inc  = pls_in;
          end else if (pls_in) begin
            w_next = ST_ON;
          end else begin
            w_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
          w_inc      = pls_in;
        end
      end
      default: begin
        w_next     = ST_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_led   <= (w_next == ST_ON);
      r_busy  <= (w_next != ST_IDLE);
    end
  end

  assign led_out = r_led;
  assign busy    = r_busy;
  assign pending = w_count;

`ifdef LED_STRETCH_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with HOLD=8, GAP=4, PEND_W=2.
// Edge e counts posedges after the stimulus starts; a pulse driven in
// cycle e-1 is sampled at edge e, outputs are checked 1ns after edge e.
module tb_led_pulse_stretcher;

  logic       clk;
  logic       rst;
  logic       pls_in;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
`ifdef LED_STRETCH_OVF_EN
  logic       ovf;
`endif

  int vectors;
  int miscompares;

  led_pulse_stretcher #(
    .HOLD_CYCLES(8),
    .GAP_CYCLES (4),
    .PEND_W     (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pls_in  (pls_in),
    .led_out (led_out),
    .busy    (busy),
`ifdef LED_STRETCH_OVF_EN
    .pending (pending),
    .ovf     (ovf)
`else
    .pending (pending)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic p);
    pls_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    pls_in = 1'b0;
    tick(1'b0);
    tick(1'b0);
    vectors++;
    if (led_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_led: led_out=%b expected 0", led_out);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: busy=%b expected 0", busy);
    end
    vectors++;
    if (pending !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_pending: pending=%0d expected 0", pending);
    end
`ifdef LED_STRETCH_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: ovf=%b expected 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic exp_led, exp_busy;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      tick(e == 1);
      exp_led  = (e <= 8);
      exp_busy = (e <= 12);
      vectors++;
      if (led_out !== exp_led) begin
        miscompares++;
        $display("FAIL single_led: e=%0d led_out=%b expected %b", e, led_out, exp_led);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL single_busy: e=%0d busy=%b expected %b", e, busy, exp_busy);
      end
      vectors++;
      if (pending !== 2'd0) begin
        miscompares++;
        $display("FAIL single_pending: e=%0d pending=%0d expected 0", e, pending);
      end
    end
  endtask

  task automatic test_three();
    logic       exp_led, exp_busy;
    logic [1:0] exp_pend;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      tick((e == 1) || (e == 3) || (e == 6));
      exp_led  = (e <= 36) && (((e - 1) % 12) < 8);
      exp_busy = (e <= 36);
      if (e >= 3 && e <= 5)        exp_pend = 2'd1;
      else if (e >= 6 && e <= 12)  exp_pend = 2'd2;
      else if (e >= 13 && e <= 24) exp_pend = 2'd1;
      else                         exp_pend = 2'd0;
      vectors++;
      if (led_out !== exp_led) begin
        miscompares++;
        $display("FAIL three_led: e=%0d led_out=%b expected %b", e, led_out, exp_led);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL three_busy: e=%0d busy=%b expected %b", e, busy, exp_busy);
      end
      vectors++;
      if (pending !== exp_pend) begin
        miscompares++;
        $display("FAIL three_pending: e=%0d pending=%0d expected %0d", e, pending, exp_pend);
      end
    end
  endtask

  task automatic test_saturate();
    logic       exp_led, exp_busy;
    logic [1:0] exp_pend;
    do_reset();
    for (int e = 1; e <= 52; e++) begin
      tick(e <= 5);
      exp_led  = (e <= 48) && (((e - 1) % 12) < 8);
      exp_busy = (e <= 48);
      if (e == 2)                  exp_pend = 2'd1;
      else if (e == 3)             exp_pend = 2'd2;
      else if (e >= 4 && e <= 12)  exp_pend = 2'd3;
      else if (e >= 13 && e <= 24) exp_pend = 2'd2;
      else if (e >= 25 && e <= 36) exp_pend = 2'd1;
      else                         exp_pend = 2'd0;
      vectors++;
      if (led_out !== exp_led) begin
        miscompares++;
        $display("FAIL sat_led: e=%0d led_out=%b expected %b", e, led_out, exp_led);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL sat_busy: e=%0d busy=%b expected %b", e, busy, exp_busy);
      end
      vectors++;
      if (pending !== exp_pend) begin
        miscompares++;
        $display("FAIL sat_pending: e=%0d pending=%0d expected %0d", e, pending, exp_pend);
      end
`ifdef LED_STRETCH_OVF_EN
      vectors++;
      if (ovf !== (e >= 5)) begin
        miscompares++;
        $display("FAIL sat_ovf: e=%0d ovf=%b expected %b", e, ovf, (e >= 5));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic exp_led, exp_busy;
    do_reset();
    // Second pulse lands in the final GAP cycle of the first blink.
    for (int e = 1; e <= 28; e++) begin
      tick((e == 1) || (e == 13));
      exp_led  = (e <= 8) || (e >= 13 && e <= 20);
      exp_busy = (e <= 24);
      vectors++;
      if (led_out !== exp_led) begin
        miscompares++;
        $display("FAIL b2b_led: e=%0d led_out=%b expected %b", e, led_out, exp_led);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL b2b_busy: e=%0d busy=%b expected %b", e, busy, exp_busy);
      end
      vectors++;
      if (pending !== 2'd0) begin
        miscompares++;
        $display("FAIL b2b_pending: e=%0d pending=%0d expected 0", e, pending);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    vectors++;
    if (pending !== 2'd2) begin
      miscompares++;
      $display("FAIL midrst_pre_pending: pending=%0d expected 2", pending);
    end
    vectors++;
    if (led_out !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre_led: led_out=%b expected 1", led_out);
    end
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    vectors++;
    if (led_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_led: led_out=%b expected 0", led_out);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_busy: busy=%b expected 0", busy);
    end
    vectors++;
    if (pending !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_pending: pending=%0d expected 0", pending);
    end
    for (int e = 1; e <= 30; e++) begin
      tick(1'b0);
      vectors++;
      if ({led_out, busy, pending} !== 4'b0000) begin
        miscompares++;
        $display("FAIL midrst_after: e=%0d led_out=%b busy=%b pending=%0d expected all 0",
                 e, led_out, busy, pending);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    pls_in      = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
